// File: rtl/word_lit_decoder.sv
// word_lit_decoder: decodes 16-bit literal words back to bytes through a small FIFO.
// Optional WORD_LIT_DEC_STATS_EN adds a saturating malformed-word counter on err_count.
module word_lit_decoder #(
    parameter int DEPTH       = 4,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [15:0] in_word,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_err,
    output logic        halted,
    output logic [7:0]  err_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {PRIME, RUN, HALT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];
    logic          bad, flush, push, pop;

    assign in_ready  = (state_q == RUN) && (count_q != (AW+1)'(DEPTH));
    assign out_valid = count_q != '0;
    assign halted    = state_q == HALT;
    assign {out_err, out_byte} = mem_q[rd_ptr_q];
    assign bad   = |in_word[15:8];
    assign flush = clr && (state_q != PRIME);
    assign push  = in_valid && in_ready && !flush;
    assign pop   = out_valid && out_ready && !flush;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {bad, in_word[7:0] ^ 8'h01};
        wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + 1'b1 : wr_ptr_q);
        rd_ptr_d = flush ? '0 : (pop ? rd_ptr_q + 1'b1 : rd_ptr_q);
        count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d  = flush || (state_q == PRIME) ? RUN :
                   (push && bad && STOP_ON_ERR) ? HALT : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= PRIME;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef WORD_LIT_DEC_STATS_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    assign err_cnt_d = (push && bad && !(&err_cnt_q)) ? err_cnt_q + 8'd1 : err_cnt_q;
    assign err_count = err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt_q <= '0;
        else      err_cnt_q <= err_cnt_d;
    end
`else
    assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_word_lit_decoder.sv
// tb_word_lit_decoder: directed vector table plus hand sequences for halt, clear, saturation and reset.
module tb_word_lit_decoder;
`ifdef WORD_LIT_DEC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_word = 16'h0000;
    logic        in_ready, out_valid, out_err, halted;
    logic [7:0]  out_byte, err_count;
    logic        in_ready1, out_valid1, out_err1, halted1;
    logic [7:0]  out_byte1, err_count1;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    word_lit_decoder #(.DEPTH(4), .STOP_ON_ERR(1'b1)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_err(out_err), .halted(halted), .err_count(err_count)
    );

    word_lit_decoder #(.DEPTH(4), .STOP_ON_ERR(1'b0)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_byte(out_byte1), .out_err(out_err1), .halted(halted1), .err_count(err_count1)
    );

    typedef struct {
        logic        iv;
        logic [15:0] word;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [7:0]  exp_byte;
        logic        exp_err;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // cycle 0 is the PRIME cycle right after reset release
        tbl[0]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[3]  = '{1'b1, 16'h00FE, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 16'h00FF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b0};
        tbl[6]  = '{1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[8]  = '{1'b1, 16'h0012, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[9]  = '{1'b1, 16'h0013, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[10] = '{1'b1, 16'h0014, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[11] = '{1'b1, 16'h0014, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[12] = '{1'b1, 16'h0014, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

        repeat (3) step();
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_byte",  16'(out_byte),  16'h0);
        chk("rst_out_err",   16'(out_err),   16'h0);
        chk("rst_halted",    16'(halted),    16'h0);
        chk("rst_in_ready",  16'(in_ready),  16'h0);
        chk("rst_err_count", 16'(err_count), 16'h0);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            in_valid  = tbl[i].iv;
            in_word   = tbl[i].word;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i),  16'(in_ready),  16'(tbl[i].exp_ir));
            chk($sformatf("v%0d_out_valid", i), 16'(out_valid), 16'(tbl[i].exp_ov));
            chk($sformatf("v%0d_halted", i),    16'(halted),    16'h0);
            if (tbl[i].exp_ov) begin
                chk($sformatf("v%0d_out_byte", i), 16'(out_byte), 16'(tbl[i].exp_byte));
                chk($sformatf("v%0d_out_err", i),  16'(out_err),  16'(tbl[i].exp_err));
            end
            step();
        end

        // malformed word: halts u0, u1 keeps running
        in_valid = 1'b1; in_word = 16'h0105; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("bad_out_valid", 16'(out_valid), 16'h1);
        chk("bad_out_byte",  16'(out_byte),  16'h04);
        chk("bad_out_err",   16'(out_err),   16'h1);
        chk("bad_halted",    16'(halted),    16'h1);
        chk("bad_in_ready",  16'(in_ready),  16'h0);
        chk("bad_u1_halted", 16'(halted1),   16'h0);
        chk("bad_u1_ready",  16'(in_ready1), 16'h1);
        step();
        chk("halt_stays",    16'(halted),    16'h1);
        chk("bad_err_count", 16'(err_count), STATS ? 16'h1 : 16'h0);
        clr = 1'b1; in_valid = 1'b1; in_word = 16'h0007;
        step();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_halted",    16'(halted),     16'h0);
        chk("clr_out_valid", 16'(out_valid),  16'h0);
        chk("clr_in_ready",  16'(in_ready),   16'h1);
        chk("clr_u1_valid",  16'(out_valid1), 16'h0);
        chk("clr_err_kept",  16'(err_count),  STATS ? 16'h1 : 16'h0);

        // saturation run on the non-stopping instance
        in_valid = 1'b1; in_word = 16'hFF00; out_ready = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            chk("sat_u1_valid",  16'(out_valid1), 16'h1);
            chk("sat_u1_err",    16'(out_err1),   16'h1);
            chk("sat_u1_byte",   16'(out_byte1),  16'h01);
            chk("sat_u1_halted", 16'(halted1),    16'h0);
            step();
        end
        in_valid = 1'b0;
        chk("sat_u1_count", 16'(err_count1), STATS ? 16'hFF : 16'h0);
        chk("sat_u0_count", 16'(err_count),  STATS ? 16'h2 : 16'h0);
        chk("sat_u0_halted", 16'(halted),    16'h1);

        // reset mid-stream with three entries queued
        clr = 1'b1;
        step();
        clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        in_word = 16'h0020; step();
        in_word = 16'h0021; step();
        in_word = 16'h0022; step();
        in_valid = 1'b0;
        chk("q3_out_valid", 16'(out_valid), 16'h1);
        chk("q3_out_byte",  16'(out_byte),  16'h21);
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 16'(out_valid),  16'h0);
        chk("arst_out_byte",  16'(out_byte),   16'h0);
        chk("arst_in_ready",  16'(in_ready),   16'h0);
        chk("arst_err_count", 16'(err_count1), 16'h0);
        step();
        rst = 1'b1;
        chk("prime_in_ready", 16'(in_ready),  16'h0);
        step();
        chk("run_in_ready",   16'(in_ready),  16'h1);
        chk("run_out_valid",  16'(out_valid), 16'h0);
        in_valid = 1'b1; in_word = 16'h0041;
        step();
        in_valid = 1'b0;
        chk("post_out_valid", 16'(out_valid), 16'h1);
        chk("post_out_byte",  16'(out_byte),  16'h40);
        chk("post_out_err",   16'(out_err),   16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/word_lit_decoder.md
Name: word_lit_decoder

Overview:
- Receive side of the byte-to-word literal stream. The upstream encoder emits word = zero_extend16(b) ^ 16'h0001 for each input byte b.
- This block accepts 16-bit words, recovers b = word[7:0] ^ 8'h01, and checks that word[15:8] == 8'h00.
- Decoded bytes are buffered in a small FIFO and presented with a valid/ready handshake.
- Sits downstream of the encoder in loopback and regression harnesses.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
STOP_ON_ERR, 1, 1 = enter HALT on first malformed word; 0 = flag the byte and keep running

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
clr  input  1  synchronous clear: flush FIFO, leave HALT
in_valid  input  1  in_word valid this cycle
in_word  input  16  encoded word
in_ready  output  1  block accepts in_word this cycle
out_valid  output  1  out_byte/out_err valid
out_ready  input  1  consumer takes the head entry this cycle
out_byte  output  8  decoded byte
out_err  output  1  head entry came from a malformed word (word[15:8] != 0)
halted  output  1  block is in HALT
err_count  output  8  saturating malformed-word count (see Optional Feature)

Behaviour:
- States: PRIME, RUN, HALT. Reset (rst = 0) enters PRIME.
- Values while in reset: out_valid=0, out_byte=8'h00, out_err=0, halted=0, in_ready=0, err_count=0, FIFO pointers and count at 0.
- PRIME lasts exactly one clk cycle after rst deasserts. in_ready=0 in PRIME. PRIME -> RUN unconditionally.
- RUN: in_ready = (count != DEPTH). A push happens when in_valid & in_ready.
- Push writes {err = |in_word[15:8], byte = in_word[7:0] ^ 8'h01}.
- Latency: a word pushed in cycle N into an empty FIFO appears at out_valid/out_byte in cycle N+1. There is no combinational bypass.
- Outputs out_byte and out_err are driven from the FIFO head register. out_valid = (count != 0).
- A pop happens when out_valid & out_ready. A pop on an empty FIFO has no effect.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push while full is impossible because in_ready=0. A pop while full frees the slot in the following cycle, not the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Malformed word with STOP_ON_ERR=1:
  - The entry is still pushed with err=1.
  - Next state is HALT. in_ready=0 from the next cycle.
  - Existing entries, including the bad one, remain poppable in HALT.
- Malformed word with STOP_ON_ERR=0: entry is pushed with err=1; the block stays in RUN.
- HALT: halted=1, in_ready=0. It exits only through clr or reset.
- clr=1 from RUN or HALT:
  - Next cycle: RUN, count=0, pointers=0, out_valid=0, halted=0.
  - A push or pop in the clr cycle is discarded.
  - err_count is not cleared.
- clr in PRIME is ignored.
- rst asserted mid-transfer: immediate return to reset values; FIFO contents are lost.

Optional Feature:
Macro WORD_LIT_DEC_STATS_EN.
- Defined: err_count increments by 1 on each pushed malformed word and saturates at 8'hFF. It is cleared only by rst.
- Not defined: err_count is tied to 8'h00 and no counter logic exists. All other behaviour is identical.

Test Plan:
- Reset, release, in_valid=1 with word 16'h0000 every cycle, out_ready=1:
  - in_ready=0 in the first cycle after release.
  - First push in cycle 2; out_byte=8'h01, out_err=0 one cycle later.
- Stream words 16'h0001, 16'h00FE, 16'h00FF with out_ready=1 -> out_byte sequence 8'h00, 8'hFF, 8'hFE, each one cycle after acceptance, out_err=0.
- out_ready=0, push 5 words with DEPTH=4:
  - in_ready drops after the 4th push.
  - Raise out_ready: bytes emerge in order and in_ready reasserts one cycle after the first pop.
- STOP_ON_ERR=1, push 16'h0105:
  - out_byte=8'h04 with out_err=1.
  - halted=1 and in_ready=0 the next cycle.
  - Pulse clr: halted=0, out_valid=0, in_ready=1.
- STOP_ON_ERR=0 with WORD_LIT_DEC_STATS_EN defined, push 300 words of 16'hFF00 -> every out_err=1, err_count saturates at 8'hFF, halted stays 0.
- Assert rst mid-stream with 3 entries queued -> out_valid=0 immediately; after release, PRIME for one cycle, then normal operation with the FIFO empty.
